// File: rtl/strobe_fifo_pkg.sv
// Shared constants and elaboration-time helpers for strobe_fifo.
// Strobe qualification is chosen with the STROBE_FIFO_EDGE_DETECT_EN macro.
package strobe_fifo_pkg;

    localparam logic ERR_RESET  = 1'b0;
    localparam logic HIST_RESET = 1'b1;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int depth, input int af, input int ae);
        return is_pow2(depth) && (depth >= 2) && (af <= depth) && (ae < depth);
    endfunction

endpackage

// File: rtl/strobe_fifo_edge.sv
// Rising-edge qualifier for one strobe. History resets high so a strobe
// held across reset release does not count until it drops and rises again.
module strobe_edge_detect
    import strobe_fifo_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic strobe,
    output logic rise
);

    logic strobe_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) strobe_d <= HIST_RESET;
        else       strobe_d <= strobe;
    end

    assign rise = strobe & ~strobe_d;

endmodule

// File: rtl/strobe_fifo.sv
// Synchronous show-ahead FIFO with thresholds, sticky errors and flush.
// Define STROBE_FIFO_EDGE_DETECT_EN for edge-qualified strobes; default is level.
module strobe_fifo
    import strobe_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    write_en,
    input  logic                    read_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

    if (!params_legal(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("strobe_fifo: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         level_q;
    logic                  wr_req, rd_req, wr_acc, rd_acc;

`ifdef STROBE_FIFO_EDGE_DETECT_EN
    strobe_edge_detect u_wr_edge (.clock(clock), .reset(reset), .strobe(write_en), .rise(wr_req));
    strobe_edge_detect u_rd_edge (.clock(clock), .reset(reset), .strobe(read_en),  .rise(rd_req));
`else
    assign wr_req = write_en;
    assign rd_req = read_en;
`endif

    // A request is accepted when it fires and the FIFO can honour it this cycle;
    // a full FIFO still takes a write if a read frees a slot on the same edge.
    // An empty FIFO never bypasses, so a read there is rejected even with a write.
    assign rd_acc = rd_req & ~empty;
    assign wr_acc = wr_req & (~full | rd_acc);

    always_ff @(posedge clock) begin
        if (wr_acc && !flush && !reset) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            overflow  <= ERR_RESET;
            underflow <= ERR_RESET;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            overflow  <= ERR_RESET;
            underflow <= ERR_RESET;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            if (wr_acc && !rd_acc)      level_q <= level_q + LW'(1);
            else if (rd_acc && !wr_acc) level_q <= level_q - LW'(1);
            if (wr_req && !wr_acc) overflow  <= 1'b1;
            if (rd_req && !rd_acc) underflow <= 1'b1;
        end
    end

    assign level        = level_q;
    assign empty        = (level_q == '0);
    assign full         = (level_q == DEPTH_L);
    assign almost_full  = (level_q >= AF_L);
    assign almost_empty = (level_q <= AE_L);
    assign data_out     = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_strobe_fifo.sv
// Directed bench for strobe_fifo: a spec-level occupancy model plus an
// expected-data queue predicts every output after each operation.
module tb_strobe_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]    level;

    strobe_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .write_en(write_en), .read_en(read_en), .data_in(data_in),
        .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow)
    );

    // clock / reset
    always #5 clock = ~clock;

    // scoreboard state
    logic [DW-1:0] exp_q[$];
    int mdl_level = 0;
    bit mdl_ovf = 0;
    bit mdl_unf = 0;
    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [DW-1:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : '0;
        check_eq({tag, ".level"},     32'(level),        32'(mdl_level));
        check_eq({tag, ".empty"},     32'(empty),        32'(mdl_level == 0));
        check_eq({tag, ".full"},      32'(full),         32'(mdl_level == DEPTH));
        check_eq({tag, ".af"},        32'(almost_full),  32'(mdl_level >= AF));
        check_eq({tag, ".ae"},        32'(almost_empty), 32'(mdl_level <= AE));
        check_eq({tag, ".overflow"},  32'(overflow),     32'(mdl_ovf));
        check_eq({tag, ".underflow"}, 32'(underflow),    32'(mdl_unf));
        check_eq({tag, ".data_out"},  32'(data_out),     32'(head));
    endtask

    // driver: one-cycle strobe pulse followed by one idle cycle
    task automatic do_op(input string tag, input logic wr, input logic rd, input logic [DW-1:0] d);
        bit rd_ok, wr_ok;
        rd_ok = rd && (mdl_level > 0);
        wr_ok = wr && ((mdl_level < DEPTH) || rd_ok);
        write_en = wr;
        read_en  = rd;
        data_in  = d;
        @(posedge clock); #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        if (rd_ok) void'(exp_q.pop_front());
        if (wr_ok) exp_q.push_back(d);
        if (wr && !wr_ok) mdl_ovf = 1'b1;
        if (rd && !rd_ok) mdl_unf = 1'b1;
        mdl_level = mdl_level + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
        @(posedge clock); #1;
        check_state(tag);
    endtask

    task automatic do_flush(input logic wr, input logic [DW-1:0] d);
        flush    = 1'b1;
        write_en = wr;
        data_in  = d;
        @(posedge clock); #1;
        flush    = 1'b0;
        write_en = 1'b0;
        exp_q.delete();
        mdl_level = 0;
        mdl_ovf = 1'b0;
        mdl_unf = 1'b0;
        @(posedge clock); #1;
        check_state("flush");
    endtask

    int ph_cnt[7] = '{13, 11, 12, 5, 10, 10, 14};
    bit ph_wr[7]  = '{1, 0, 1, 1, 0, 1, 0};
    bit ph_rd[7]  = '{0, 1, 0, 1, 1, 0, 1};

    initial begin
`ifdef STROBE_FIFO_EDGE_DETECT_EN
        write_en = 1'b1;
        data_in  = 8'h5A;
`endif
        repeat (3) @(posedge clock);
        #1;
        check_state("reset");
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
`ifdef STROBE_FIFO_EDGE_DETECT_EN
        // strobe held through reset release must not count
        check_state("held_strobe");
        write_en = 1'b0;
        @(posedge clock); #1;
        do_op("edge_wr", 1'b1, 1'b0, 8'hA5);
        do_op("edge_rd", 1'b0, 1'b1, 8'h00);
`endif

        // fill to full, then one rejected write
        for (int i = 0; i < DEPTH; i++) do_op("fill", 1'b1, 1'b0, DW'(i));
        do_op("overflow", 1'b1, 1'b0, 8'hEE);

        // drain in order, then one rejected read
        for (int i = 0; i < DEPTH; i++) do_op("drain", 1'b0, 1'b1, 8'h00);
        do_op("underflow", 1'b0, 1'b1, 8'h00);
        do_flush(1'b0, 8'h00);

        // full FIFO with simultaneous read and write
        for (int i = 0; i < DEPTH; i++) do_op("fill2", 1'b1, 1'b0, DW'(8'h10 + i));
        do_op("full_rw", 1'b1, 1'b1, 8'h55);
        for (int i = 0; i < DEPTH; i++) do_op("drain2", 1'b0, 1'b1, 8'h00);

        // 40 words of interleaved traffic across the pointer wrap
        begin
            int w;
            w = 0;
            for (int p = 0; p < 7; p++) begin
                for (int k = 0; k < ph_cnt[p]; k++) begin
                    do_op("mix", ph_wr[p], ph_rd[p], DW'(8'h80 + w));
                    if (ph_wr[p]) w++;
                end
            end
            check_eq("mix.words", 32'(w), 32'd40);
        end

        // flush at level 7 with sticky overflow and a same-cycle write
        for (int i = 0; i < DEPTH; i++) do_op("fill3", 1'b1, 1'b0, DW'(8'hC0 + i));
        do_op("overflow3", 1'b1, 1'b0, 8'hEF);
        for (int i = 0; i < 9; i++) do_op("drain3", 1'b0, 1'b1, 8'h00);
        check_eq("pre_flush.level", 32'(level), 32'd7);
        do_flush(1'b1, 8'h77);
        do_op("post_flush_wr", 1'b1, 1'b0, 8'h3C);
        do_op("post_flush_rd", 1'b0, 1'b1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
